// File: rtl/ethernet_link_failover_mux.sv
// N-port priority uplink selector with debounced takeover and frame-safe RX/TX switching.
// Optional saturating performance counters are enabled with `define ETH_LINK_MUX_PERF_EN.
package ethernet_link_failover_mux_pkg;
    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
    } ethernet_rx_bus_t;
endpackage

module ethernet_link_failover_mux
    import ethernet_link_failover_mux_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned HOLDOFF_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PORTS-1:0]             link_up_i,
    input  ethernet_rx_bus_t [NUM_PORTS-1:0] rx_bus_i,
    output ethernet_rx_bus_t                 muxed_rx_bus_o,
    input  logic                             tx_frame_start_i,
    input  logic                             tx_frame_end_i,
    output logic [NUM_PORTS-1:0]             tx_port_en_o,
    output logic [$clog2(NUM_PORTS)-1:0]     active_port_o,
    output logic                             any_link_up_o
`ifdef ETH_LINK_MUX_PERF_EN
    ,
    output logic [31:0]                      perf_switches_o,
    output logic [31:0]                      perf_rx_aborts_o,
    output logic [15:0]                      perf_holdoff_restarts_o
`endif
);

    localparam int unsigned PORT_BITS = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W     = $clog2(HOLDOFF_CYCLES + 1);
    // Terminal count is checked one cycle early so the takeover lands HOLDOFF_CYCLES after the rise.
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 2 : 0);

    // NO_LINK: no port up | ACTIVE: forwarding | PENDING: holdoff running | SWITCH: draining
    typedef enum logic [1:0] {NO_LINK, ACTIVE, PENDING, SWITCH} state_e;

    state_e                 state_q, state_d;
    logic [PORT_BITS-1:0]   active_q, active_d;
    logic [PORT_BITS-1:0]   target_q, target_d;
    logic [PORT_BITS-1:0]   best, sw_tgt;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]   tx_en_q, tx_en_d;
    ethernet_rx_bus_t       muxed_q, muxed_d, rx_cur;
    logic                   any_up_q;
    logic                   rx_open_q, rx_open_d, tx_open_q, tx_open_d;
    logic                   any_up, act_up, rx_open_nxt, tx_open_nxt;
    logic                   rx_idle, tx_idle, inject_drop;

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [PORT_BITS-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        best = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (link_up_i[i]) begin
                best = PORT_BITS'(i);
            end
        end
    end

    assign any_up      = |link_up_i;
    assign act_up      = link_up_i[active_q];
    assign rx_cur      = rx_bus_i[active_q];
    assign rx_open_nxt = (rx_cur.commit || rx_cur.drop) ? 1'b0 : (rx_cur.start || rx_open_q);
    assign tx_open_nxt = tx_frame_end_i ? 1'b0 : (tx_frame_start_i || tx_open_q);
    assign rx_idle     = !act_up || !rx_open_nxt;
    assign tx_idle     = !tx_open_nxt;
    assign inject_drop = (state_q != NO_LINK) && !act_up && rx_open_q;
    assign sw_tgt      = link_up_i[target_q] ? target_q : best;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        tx_en_d   = tx_en_q;
        muxed_d   = '0;
        rx_open_d = 1'b0;
        tx_open_d = tx_open_nxt;

        if (state_q != NO_LINK) begin
            muxed_d   = rx_cur;
            rx_open_d = rx_open_nxt;
        end

        unique case (state_q)
            NO_LINK: begin
                tx_en_d = '0;
                if (any_up) begin
                    state_d  = ACTIVE;
                    active_d = best;
                    if (tx_idle) begin
                        tx_en_d = onehot(best);
                    end
                end
            end
            ACTIVE, PENDING: begin
                if (!act_up) begin
                    tx_open_d = 1'b0;
                    tx_en_d   = '0;
                    rx_open_d = 1'b0;
                    cnt_d     = '0;
                    if (any_up) begin
                        state_d  = SWITCH;
                        target_d = best;
                    end else begin
                        state_d = NO_LINK;
                    end
                end else begin
                    if (tx_idle) begin
                        tx_en_d = onehot(active_q);
                    end
                    if (best == active_q) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else if (state_q == ACTIVE || best != target_q) begin
                        state_d  = PENDING;
                        target_d = best;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == HOLD_TC) begin
                            state_d = SWITCH;
                        end
                    end
                end
            end
            SWITCH: begin
                if (!act_up) begin
                    // Dead current link counts as RX idle and any TX frame is abandoned.
                    tx_open_d = 1'b0;
                    tx_en_d   = '0;
                    rx_open_d = 1'b0;
                    cnt_d     = '0;
                    if (any_up) begin
                        state_d  = ACTIVE;
                        active_d = best;
                        tx_en_d  = onehot(best);
                    end else begin
                        state_d = NO_LINK;
                    end
                end else if (sw_tgt == active_q) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    if (tx_idle) begin
                        tx_en_d = onehot(active_q);
                    end
                end else if (rx_idle && tx_idle) begin
                    state_d   = ACTIVE;
                    active_d  = sw_tgt;
                    tx_en_d   = onehot(sw_tgt);
                    rx_open_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    target_d = sw_tgt;
                end
            end
        endcase

        if (inject_drop) begin
            muxed_d      = '0;
            muxed_d.drop = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= NO_LINK;
            active_q  <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            tx_en_q   <= '0;
            muxed_q   <= '0;
            any_up_q  <= 1'b0;
            rx_open_q <= 1'b0;
            tx_open_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            tx_en_q   <= tx_en_d;
            muxed_q   <= muxed_d;
            any_up_q  <= any_up;
            rx_open_q <= rx_open_d;
            tx_open_q <= tx_open_d;
        end
    end

    assign muxed_rx_bus_o = muxed_q;
    assign tx_port_en_o   = tx_en_q;
    assign active_port_o  = active_q;
    assign any_link_up_o  = any_up_q;

`ifdef ETH_LINK_MUX_PERF_EN
    logic        switched, restarted;
    logic [31:0] perf_sw_q, perf_ab_q;
    logic [15:0] perf_rs_q;

    assign switched  = (active_d != active_q);
    assign restarted = (state_q == PENDING) && act_up && (best != active_q) && (best != target_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_sw_q <= '0;
            perf_ab_q <= '0;
            perf_rs_q <= '0;
        end else begin
            if (switched && perf_sw_q != '1) begin
                perf_sw_q <= perf_sw_q + 1'b1;
            end
            if (inject_drop && perf_ab_q != '1) begin
                perf_ab_q <= perf_ab_q + 1'b1;
            end
            if (restarted && perf_rs_q != '1) begin
                perf_rs_q <= perf_rs_q + 1'b1;
            end
        end
    end

    assign perf_switches_o         = perf_sw_q;
    assign perf_rx_aborts_o        = perf_ab_q;
    assign perf_holdoff_restarts_o = perf_rs_q;
`endif

endmodule

// File: tb/tb_ethernet_link_failover_mux.sv
// Directed bench for ethernet_link_failover_mux: a 2-port and a 4-port instance, holdoff 16.
module tb_ethernet_link_failover_mux;
    import ethernet_link_failover_mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]             link2;
    ethernet_rx_bus_t [1:0] rx2;
    ethernet_rx_bus_t       mux2;
    logic                   txs2, txe2;
    logic [1:0]             en2;
    logic [0:0]             act2;
    logic                   any2;

    logic [3:0]             link4;
    ethernet_rx_bus_t [3:0] rx4;
    ethernet_rx_bus_t       mux4;
    logic                   txs4, txe4;
    logic [3:0]             en4;
    logic [1:0]             act4;
    logic                   any4;

`ifdef ETH_LINK_MUX_PERF_EN
    logic [31:0] psw2, pab2, psw4, pab4;
    logic [15:0] prs2, prs4;
`endif

    ethernet_link_failover_mux #(.NUM_PORTS(2), .HOLDOFF_CYCLES(16)) u_dut2 (
        .clk_i            (clk),
        .rst_i            (rst),
        .link_up_i        (link2),
        .rx_bus_i         (rx2),
        .muxed_rx_bus_o   (mux2),
        .tx_frame_start_i (txs2),
        .tx_frame_end_i   (txe2),
        .tx_port_en_o     (en2),
        .active_port_o    (act2),
        .any_link_up_o    (any2)
`ifdef ETH_LINK_MUX_PERF_EN
        ,
        .perf_switches_o         (psw2),
        .perf_rx_aborts_o        (pab2),
        .perf_holdoff_restarts_o (prs2)
`endif
    );

    ethernet_link_failover_mux #(.NUM_PORTS(4), .HOLDOFF_CYCLES(16)) u_dut4 (
        .clk_i            (clk),
        .rst_i            (rst),
        .link_up_i        (link4),
        .rx_bus_i         (rx4),
        .muxed_rx_bus_o   (mux4),
        .tx_frame_start_i (txs4),
        .tx_frame_end_i   (txe4),
        .tx_port_en_o     (en4),
        .active_port_o    (act4),
        .any_link_up_o    (any4)
`ifdef ETH_LINK_MUX_PERF_EN
        ,
        .perf_switches_o         (psw4),
        .perf_rx_aborts_o        (pab4),
        .perf_holdoff_restarts_o (prs4)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    ethernet_rx_bus_t drop_only;
    ethernet_rx_bus_t exp_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ethernet_rx_bus_t mk_beat(input int k, input int last, input logic [31:0] base);
        ethernet_rx_bus_t b;
        b             = '0;
        b.data_valid  = 1'b1;
        b.bytes_valid = 3'd4;
        b.data        = base + 32'(k);
        b.start       = (k == 0);
        b.commit      = (k == last);
        return b;
    endfunction

    initial begin
        rst = 1'b1;
        link2 = '0; rx2 = '0; txs2 = 1'b0; txe2 = 1'b0;
        link4 = '0; rx4 = '0; txs4 = 1'b0; txe4 = 1'b0;
        drop_only = '0;
        drop_only.drop = 1'b1;
        repeat (3) tick();
        check("rst_mux", 64'(mux2), 64'd0);
        check("rst_en", 64'(en2), 64'd0);
        check("rst_act", 64'(act2), 64'd0);
        check("rst_any", 64'(any2), 64'd0);
        rst = 1'b0;

        // no link: RX noise on port1 must not leak
        rx2[1] = mk_beat(3, 9, 32'hDEAD0000);
        repeat (6) tick();
        check("nolink_en", 64'(en2), 64'd0);
        check("nolink_mux", 64'(mux2), 64'd0);
        rx2[1] = '0;

        // port1 alone comes up: immediate selection
        link2 = 2'b10;
        tick();
        check("up1_act", 64'(act2), 64'd1);
        check("up1_en", 64'(en2), 64'h2);
        check("up1_any", 64'(any2), 64'd1);
        check("up1_mux", 64'(mux2), 64'd0);
        for (int k = 0; k <= 2; k++) begin
            exp_b  = mk_beat(k, 2, 32'h10000000);
            rx2[1] = exp_b;
            tick();
            check("p1_mirror", 64'(mux2), 64'(exp_b));
        end
        rx2[1] = '0;

        // port0 takeover with a one-cycle glitch at count 8
        link2 = 2'b11;
        tick();
        repeat (8) tick();
        link2 = 2'b10;
        tick();
        link2 = 2'b11;
        tick();
        repeat (6) tick();
        check("glitch_hold_a", 64'(act2), 64'd1);
        repeat (9) tick();
        check("glitch_hold_b", 64'(act2), 64'd1);
        tick();
        check("takeover_act", 64'(act2), 64'd0);
        check("takeover_en", 64'(en2), 64'h1);

        // port0 drops without an RX frame: failover to port1
        link2 = 2'b10;
        tick();
        check("fo_en_clear", 64'(en2), 64'd0);
        check("fo_act_old", 64'(act2), 64'd0);
        tick();
        check("fo_act_new", 64'(act2), 64'd1);
        check("fo_en_new", 64'(en2), 64'h2);

        // takeover pending while a 41-beat port1 frame is open
        link2 = 2'b11;
        for (int k = 0; k <= 40; k++) begin
            exp_b  = mk_beat(k, 40, 32'h20000000);
            rx2[1] = exp_b;
            tick();
            check("rxhold_mux", 64'(mux2), 64'(exp_b));
            check("rxhold_act", 64'(act2), (k < 40) ? 64'd1 : 64'd0);
        end
        rx2[1] = '0;
        check("rxhold_en", 64'(en2), 64'h1);

        // port0 drops mid-frame with port1 up: drop pulse then switch
        exp_b  = mk_beat(0, 5, 32'h30000000);
        rx2[0] = exp_b;
        tick();
        check("midf_start", 64'(mux2), 64'(exp_b));
        rx2[0] = mk_beat(1, 5, 32'h30000000);
        link2  = 2'b10;
        tick();
        check("midf_drop", 64'(mux2), 64'(drop_only));
        check("midf_en", 64'(en2), 64'd0);
        rx2[0] = '0;
        tick();
        check("midf_act", 64'(act2), 64'd1);
        check("midf_en_new", 64'(en2), 64'h2);
        check("midf_mux_after", 64'(mux2), 64'd0);

        // TX frame open across a takeover
        txs2 = 1'b1;
        tick();
        txs2  = 1'b0;
        link2 = 2'b11;
        tick();
        repeat (20) tick();
        check("txhold_act", 64'(act2), 64'd1);
        check("txhold_en", 64'(en2), 64'h2);
        txe2 = 1'b1;
        tick();
        txe2 = 1'b0;
        check("txend_act", 64'(act2), 64'd0);
        check("txend_en", 64'(en2), 64'h1);

        // all links lost, then rise with same-cycle TX start/end
        link2 = 2'b00;
        tick();
        check("lost_en", 64'(en2), 64'd0);
        check("lost_mux", 64'(mux2), 64'd0);
        tick();
        check("lost_any", 64'(any2), 64'd0);
        link2 = 2'b01;
        txs2  = 1'b1;
        txe2  = 1'b1;
        tick();
        txs2 = 1'b0;
        txe2 = 1'b0;
        check("same_cyc_en", 64'(en2), 64'h1);
        check("same_cyc_act", 64'(act2), 64'd0);

        // 4-port instance
        rx4[2] = mk_beat(1, 3, 32'h40000000);
        tick();
        check("p4_nolink_mux", 64'(mux4), 64'd0);
        check("p4_nolink_en", 64'(en4), 64'd0);
        check("p4_nolink_any", 64'(any4), 64'd0);
        rx4[2] = '0;
        link4  = 4'b1100;
        tick();
        check("p4_act", 64'(act4), 64'd2);
        check("p4_en", 64'(en4), 64'h4);
        check("p4_any", 64'(any4), 64'd1);
        exp_b  = mk_beat(0, 3, 32'h50000000);
        rx4[2] = exp_b;
        tick();
        check("p4_mux", 64'(mux4), 64'(exp_b));
        rx4[2] = mk_beat(1, 3, 32'h50000000);
        rst    = 1'b1;
        tick();
        check("p4_rst_mux", 64'(mux4), 64'd0);
        check("p4_rst_en", 64'(en4), 64'd0);
        check("p4_rst_act", 64'(act4), 64'd0);
        check("p4_rst_any", 64'(any4), 64'd0);
        check("p2_rst_en", 64'(en2), 64'd0);
        rst = 1'b0;
        rx4 = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
